// File: rtl/ioport_sequencer.sv
// ioport_sequencer: turns Hack CPU I/O requests into one-cycle latch strobes and runs a GPIO pulse-train engine.
// Optional feature macro IOPORT_PULSE_IRQ_EN adds the pulseDone natural-completion pulse.
module ioport_sequencer #(
  parameter int HALF_PERIOD = 8000,
  parameter int CNT_W       = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpuReq,
  input  logic        cpuWe,
  input  logic [1:0]  cpuAddr,
  input  logic [15:0] cpuWrData,
  output logic [15:0] cpuRdData,
  output logic        cpuAck,
  output logic        portData,
  output logic        ledLoad,
  output logic        gpioDir,
  output logic        gpioLoad,
  input  logic        gpioIn,
`ifdef IOPORT_PULSE_IRQ_EN
  output logic        pulseDone,
`endif
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIR  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;
  localparam int TW = $clog2(HALF_PERIOD);
  localparam logic [TW-1:0] T_LOAD = TW'(HALF_PERIOD - 1);

  logic             r_ack;
  logic [15:0]      r_rd_data;
  logic             r_cmd_pend;
  logic [CNT_W-1:0] r_cmd_cnt;
  logic             r_port_data;
  logic             r_led_load;
  logic             r_gpio_dir;
  logic             r_gpio_load;
  logic             r_sh_led;
  logic             r_sh_dir;
  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [TW-1:0]    r_timer;

  logic             w_accept;
  logic             w_cpu_strobe;
  logic             w_cpu_abort;
  logic             w_cmd_start;
  logic             w_cmd_stop;
  logic             w_busy;
  logic             w_unused_wr;
  logic [14:0]      w_cnt_ext;
  logic [15:0]      w_rd_mux;
  logic             w_eng_due;
  logic             w_eng_val;
  logic [1:0]       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_count;
  logic [TW-1:0]    w_nxt_timer;

  // A request is only taken while no ack is out, so ACK always returns to IDLE.
  assign w_accept     = cpuReq & ~r_ack;
  assign w_cpu_strobe = w_accept & cpuWe & (cpuAddr != 2'd3);
  assign w_cpu_abort  = w_accept & cpuWe & (cpuAddr == 2'd2) & w_busy;
  // Pulse commands act in the ack cycle, where no CPU strobe can compete.
  assign w_cmd_start  = r_cmd_pend & (r_cmd_cnt != '0);
  assign w_cmd_stop   = r_cmd_pend & (r_cmd_cnt == '0) & w_busy;
  assign w_busy       = (r_state != S_IDLE);
  assign w_cnt_ext    = 15'(r_count);
  assign w_unused_wr  = ^cpuWrData[15:CNT_W];

  assign cpuAck    = r_ack;
  assign cpuRdData = r_rd_data;
  assign portData  = r_port_data;
  assign ledLoad   = r_led_load;
  assign gpioDir   = r_gpio_dir;
  assign gpioLoad  = r_gpio_load;
  assign busy      = w_busy;

  always_comb begin
    w_rd_mux = 16'h0000;
    case (cpuAddr)
      2'd0:    w_rd_mux = {15'd0, r_sh_led};
      2'd1:    w_rd_mux = {15'd0, r_sh_dir};
      2'd2:    w_rd_mux = {15'd0, r_sync2};
      2'd3:    w_rd_mux = {w_busy, w_cnt_ext};
      default: w_rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    w_eng_due   = 1'b0;
    w_eng_val   = 1'b0;
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    w_nxt_timer = r_timer;
    case (r_state)
      S_IDLE: w_nxt_state = S_IDLE;
      S_DIR: begin
        w_eng_due   = 1'b1;
        w_eng_val   = 1'b1;
        w_nxt_state = S_HIGH;
        w_nxt_timer = T_LOAD;
      end
      S_HIGH: begin
        if (r_timer == '0) begin
          w_eng_due   = 1'b1;
          w_nxt_state = S_LOW;
          w_nxt_timer = T_LOAD;
        end else begin
          w_nxt_timer = r_timer - TW'(1'b1);
        end
      end
      S_LOW: begin
        if (r_timer == '0) begin
          if (r_count > CNT_W'(1'b1)) begin
            w_eng_due   = 1'b1;
            w_eng_val   = 1'b1;
            w_nxt_state = S_HIGH;
            w_nxt_count = r_count - CNT_W'(1'b1);
            w_nxt_timer = T_LOAD;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_count = '0;
          end
        end else begin
          w_nxt_timer = r_timer - TW'(1'b1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= gpioIn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ack      <= 1'b0;
      r_rd_data  <= 16'h0000;
      r_cmd_pend <= 1'b0;
      r_cmd_cnt  <= '0;
    end else begin
      r_ack      <= w_accept;
      r_rd_data  <= (w_accept & ~cpuWe) ? w_rd_mux : 16'h0000;
      r_cmd_pend <= w_accept & cpuWe & (cpuAddr == 2'd3);
      r_cmd_cnt  <= cpuWrData[CNT_W-1:0];
    end
  end

  // CPU strobes win; an engine strobe due in the same cycle is simply not issued yet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_led_load  <= 1'b0;
      r_gpio_dir  <= 1'b0;
      r_gpio_load <= 1'b0;
      r_port_data <= 1'b0;
      r_sh_led    <= 1'b0;
      r_sh_dir    <= 1'b0;
    end else begin
      r_led_load  <= 1'b0;
      r_gpio_dir  <= 1'b0;
      r_gpio_load <= 1'b0;
      r_port_data <= 1'b0;
      if (w_cpu_strobe) begin
        r_port_data <= cpuWrData[0];
        case (cpuAddr)
          2'd0: begin
            r_led_load <= 1'b1;
            r_sh_led   <= cpuWrData[0];
          end
          2'd1: begin
            r_gpio_dir <= 1'b1;
            r_sh_dir   <= cpuWrData[0];
          end
          default: r_gpio_load <= 1'b1;
        endcase
      end else if (w_cmd_start) begin
        r_gpio_dir  <= 1'b1;
        r_port_data <= 1'b1;
        r_sh_dir    <= 1'b1;
      end else if (w_cmd_stop) begin
        r_gpio_load <= 1'b1;
      end else if (w_eng_due) begin
        r_gpio_load <= 1'b1;
        r_port_data <= w_eng_val;
      end
    end
  end

  // Engine state holds entirely while its due strobe is blocked, so its timer restarts on issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_timer <= '0;
    end else if (w_cpu_abort || w_cmd_stop) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_timer <= '0;
    end else if (w_cmd_start) begin
      r_state <= S_DIR;
      r_count <= r_cmd_cnt;
      r_timer <= '0;
    end else if (!(w_eng_due && w_cpu_strobe)) begin
      r_state <= w_nxt_state;
      r_count <= w_nxt_count;
      r_timer <= w_nxt_timer;
    end
  end

`ifdef IOPORT_PULSE_IRQ_EN
  logic r_done;
  assign pulseDone = r_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_LOW) & (r_timer == '0) & (r_count == CNT_W'(1'b1))
                & ~w_cpu_abort & ~r_cmd_pend;
    end
  end
`endif

endmodule

// File: tb/tb_ioport_sequencer.sv
// Directed bench for ioport_sequencer with HALF_PERIOD = 4; labels count cycles after the request edge.
module tb_ioport_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cpuReq = 1'b0;
  logic        cpuWe = 1'b0;
  logic [1:0]  cpuAddr = 2'd0;
  logic [15:0] cpuWrData = 16'h0000;
  logic        gpioIn = 1'b0;
  logic [15:0] cpuRdData;
  logic        cpuAck, portData, ledLoad, gpioDir, gpioLoad, busy;
`ifdef IOPORT_PULSE_IRQ_EN
  logic        pulseDone;
`endif
  int n_pass = 0;
  int n_total = 0;
  logic [5:0] obs;
  logic [5:0] want;

  always #5 CLK = ~CLK;

  ioport_sequencer #(.HALF_PERIOD(4), .CNT_W(15)) dut (
    .CLK(CLK), .RST(RST), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .cpuWrData(cpuWrData), .cpuRdData(cpuRdData), .cpuAck(cpuAck), .portData(portData),
    .ledLoad(ledLoad), .gpioDir(gpioDir), .gpioLoad(gpioLoad), .gpioIn(gpioIn),
`ifdef IOPORT_PULSE_IRQ_EN
    .pulseDone(pulseDone),
`endif
    .busy(busy)
  );

  // Observed vector order: {ack, led, dir, load, data, busy}.
  assign obs = {cpuAck, ledLoad, gpioDir, gpioLoad, portData, busy};

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic req(input logic we, input logic [1:0] addr, input logic [15:0] data);
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWrData = data;
  endtask

  task automatic idle();
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 2'd0; cpuWrData = 16'h0000;
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL reset_outs got %b expected %b", obs, 6'b000000); else n_pass++;
    n_total++; if (cpuRdData !== 16'h0000) $display("FAIL reset_rd got %h expected %h", cpuRdData, 16'h0000); else n_pass++;
    RST = 1'b0; tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL post_reset got %b expected %b", obs, 6'b000000); else n_pass++;
  endtask

  task automatic test_led();
    req(1'b1, 2'd0, 16'h0001); tick();
    n_total++; if (obs !== 6'b110010) $display("FAIL led_write got %b expected %b", obs, 6'b110010); else n_pass++;
    idle(); tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL led_after got %b expected %b", obs, 6'b000000); else n_pass++;
    req(1'b0, 2'd0, 16'h0000); tick();
    n_total++; if (obs !== 6'b100000) $display("FAIL led_read_ack got %b expected %b", obs, 6'b100000); else n_pass++;
    n_total++; if (cpuRdData !== 16'h0001) $display("FAIL led_read got %h expected %h", cpuRdData, 16'h0001); else n_pass++;
    idle(); tick();
  endtask

  task automatic test_gpio();
    gpioIn = 1'b1;
    req(1'b1, 2'd1, 16'h0001); tick();
    n_total++; if (obs !== 6'b101010) $display("FAIL gpio_dir got %b expected %b", obs, 6'b101010); else n_pass++;
    idle(); tick();
    req(1'b1, 2'd2, 16'h0001); tick();
    n_total++; if (obs !== 6'b100110) $display("FAIL gpio_load got %b expected %b", obs, 6'b100110); else n_pass++;
    idle(); tick();
    req(1'b0, 2'd2, 16'h0000); tick();
    n_total++; if (cpuRdData !== 16'h0001) $display("FAIL gpio_in_hi got %h expected %h", cpuRdData, 16'h0001); else n_pass++;
    idle(); tick();
    req(1'b0, 2'd1, 16'h0000); tick();
    n_total++; if (cpuRdData !== 16'h0001) $display("FAIL dir_shadow got %h expected %h", cpuRdData, 16'h0001); else n_pass++;
    idle(); gpioIn = 1'b0; tick(); tick(); tick();
    req(1'b0, 2'd2, 16'h0000); tick();
    n_total++; if (cpuRdData !== 16'h0000) $display("FAIL gpio_in_lo got %h expected %h", cpuRdData, 16'h0000); else n_pass++;
    idle(); tick();
  endtask

  task automatic test_back_to_back();
    req(1'b1, 2'd0, 16'h0000); tick();
    n_total++; if (obs !== 6'b110000) $display("FAIL b2b_first got %b expected %b", obs, 6'b110000); else n_pass++;
    tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL b2b_gap got %b expected %b", obs, 6'b000000); else n_pass++;
    tick();
    n_total++; if (obs !== 6'b110000) $display("FAIL b2b_second got %b expected %b", obs, 6'b110000); else n_pass++;
    idle(); tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL b2b_end got %b expected %b", obs, 6'b000000); else n_pass++;
  endtask

  task automatic test_pulse_train();
    req(1'b1, 2'd3, 16'd3); tick();
    n_total++; if (obs !== 6'b100000) $display("FAIL train_ack got %b expected %b", obs, 6'b100000); else n_pass++;
    idle();
    for (int j = 2; j <= 28; j++) begin
      tick();
      want = {(j == 9 || j == 13), 1'b0, (j == 2),
              (j == 3 || j == 7 || j == 11 || j == 15 || j == 19 || j == 23),
              (j == 2 || j == 3 || j == 11 || j == 19), (j <= 26)};
      n_total++; if (obs !== want) $display("FAIL train j=%0d got %b expected %b", j, obs, want); else n_pass++;
`ifdef IOPORT_PULSE_IRQ_EN
      n_total++; if (pulseDone !== (j == 27)) $display("FAIL train_done j=%0d got %b expected %b", j, pulseDone, (j == 27)); else n_pass++;
`endif
      if (j == 9) begin
        n_total++; if (cpuRdData !== 16'h8003) $display("FAIL train_rd1 got %h expected %h", cpuRdData, 16'h8003); else n_pass++;
      end
      if (j == 13) begin
        n_total++; if (cpuRdData !== 16'h8002) $display("FAIL train_rd2 got %h expected %h", cpuRdData, 16'h8002); else n_pass++;
      end
      if (j == 8 || j == 12) req(1'b0, 2'd3, 16'h0000); else idle();
    end
  endtask

  task automatic test_collision();
    req(1'b1, 2'd3, 16'd1); tick(); idle(); tick();
    n_total++; if (obs !== 6'b001011) $display("FAIL coll_dir got %b expected %b", obs, 6'b001011); else n_pass++;
    req(1'b1, 2'd0, 16'h0001);
    for (int j = 3; j <= 13; j++) begin
      tick();
      want = {(j == 3), (j == 3), 1'b0, (j == 4 || j == 8), (j == 3 || j == 4), (j <= 11)};
      n_total++; if (obs !== want) $display("FAIL coll j=%0d got %b expected %b", j, obs, want); else n_pass++;
`ifdef IOPORT_PULSE_IRQ_EN
      n_total++; if (pulseDone !== (j == 12)) $display("FAIL coll_done j=%0d got %b expected %b", j, pulseDone, (j == 12)); else n_pass++;
`endif
      idle();
    end
  endtask

  task automatic test_abort_gpio();
    req(1'b1, 2'd3, 16'd3); tick(); idle();
    for (int j = 2; j <= 20; j++) begin
      tick();
      want = {(j == 6), 1'b0, (j == 2), (j == 3 || j == 6), (j == 2 || j == 3), (j <= 5)};
      n_total++; if (obs !== want) $display("FAIL abort2 j=%0d got %b expected %b", j, obs, want); else n_pass++;
`ifdef IOPORT_PULSE_IRQ_EN
      n_total++; if (pulseDone !== 1'b0) $display("FAIL abort2_done j=%0d got %b expected 0", j, pulseDone); else n_pass++;
`endif
      if (j == 5) req(1'b1, 2'd2, 16'h0000); else idle();
    end
  endtask

  task automatic test_abort_cmd();
    req(1'b1, 2'd3, 16'd3); tick(); idle();
    for (int j = 2; j <= 20; j++) begin
      tick();
      want = {(j == 4), 1'b0, (j == 2), (j == 3 || j == 5), (j == 2 || j == 3), (j <= 4)};
      n_total++; if (obs !== want) $display("FAIL abort3 j=%0d got %b expected %b", j, obs, want); else n_pass++;
`ifdef IOPORT_PULSE_IRQ_EN
      n_total++; if (pulseDone !== 1'b0) $display("FAIL abort3_done j=%0d got %b expected 0", j, pulseDone); else n_pass++;
`endif
      if (j == 3) req(1'b1, 2'd3, 16'h0000); else idle();
    end
    req(1'b0, 2'd3, 16'h0000); tick();
    n_total++; if (cpuRdData !== 16'h0000) $display("FAIL abort3_rd got %h expected %h", cpuRdData, 16'h0000); else n_pass++;
    idle(); tick();
  endtask

  task automatic test_rst_mid();
    req(1'b1, 2'd3, 16'd3); tick(); idle();
    tick(); tick(); tick(); tick();
    n_total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b expected 1", busy); else n_pass++;
    RST = 1'b1; tick();
    n_total++; if (obs !== 6'b000000) $display("FAIL rst_mid got %b expected %b", obs, 6'b000000); else n_pass++;
    RST = 1'b0;
    for (int j = 7; j <= 20; j++) begin
      tick();
      n_total++; if (obs !== 6'b000000) $display("FAIL rst_quiet j=%0d got %b expected %b", j, obs, 6'b000000); else n_pass++;
`ifdef IOPORT_PULSE_IRQ_EN
      n_total++; if (pulseDone !== 1'b0) $display("FAIL rst_done j=%0d got %b expected 0", j, pulseDone); else n_pass++;
`endif
    end
    req(1'b0, 2'd0, 16'h0000); tick();
    n_total++; if (cpuRdData !== 16'h0000) $display("FAIL rst_led_shadow got %h expected %h", cpuRdData, 16'h0000); else n_pass++;
    idle(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_led();
    test_gpio();
    test_back_to_back();
    test_pulse_train();
    test_collision();
    test_abort_gpio();
    test_abort_cmd();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
